// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/pause/single-step controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } run_state_e;

  // 10 ms of stable level at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/button_debouncer.sv
// Raw button to one-cycle press event: 2-FF synchronizer, debounce counter, rising-edge pulse.
module button_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d1;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  assign w_differ = (r_sync2 != r_level);
  // Flip on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_level    <= 1'b0;
      r_level_d1 <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      if (!w_differ || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
      r_level_d1 <= r_level;
      r_press    <= r_level & ~r_level_d1;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/pause/single-step sequencer: turns divider ticks into CPU clock-enables per run state.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_btn_run,
  input  logic                 i_btn_step,
  input  logic                 i_btn_pause,
  input  logic                 i_halt,
  output logic                 o_cpu_en,
  output logic [1:0]           o_run_state,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  logic                 w_run_ev;
  logic                 w_step_ev;
  logic                 w_pause_ev;
  run_state_e           r_state;
  run_state_e           w_state_d;
  logic                 r_cpu_en;
  logic                 w_cpu_en_d;
  logic [CNT_WIDTH-1:0] r_cycle_count;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_run),
    .o_press (w_run_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_step),
    .o_press (w_step_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_pause),
    .o_press (w_pause_ev)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cpu_en      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cpu_en <= w_cpu_en_d;
      if (r_cpu_en) begin
        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_halt)         w_state_d = HALT;
        else if (w_run_ev)  w_state_d = RUN;
        else if (w_step_ev) w_state_d = STEP;
      end
      RUN: begin
        if (i_halt)          w_state_d = HALT;
        else if (w_pause_ev) w_state_d = IDLE;
      end
      STEP: begin
        if (i_halt)      w_state_d = HALT;
        else if (i_tick) w_state_d = IDLE;
      end
      HALT:    w_state_d = HALT;
      default: w_state_d = IDLE;
    endcase
    // A pause landing on a tick wins, so the paused CPU never executes that instruction.
    w_cpu_en_d = i_tick && !i_halt && !w_pause_ev && ((r_state == RUN) || (r_state == STEP));
  end

  assign o_cpu_en      = r_cpu_en;
  assign o_run_state   = r_state;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: segment table, directed corner sequences, random run vs model.
module tb_cpu_run_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_tick = 1'b0;
  logic          i_run = 1'b0;
  logic          i_step = 1'b0;
  logic          i_pause = 1'b0;
  logic          i_halt = 1'b0;
  logic          o_cpu_en;
  logic [1:0]    o_run_state;
  logic [CW-1:0] o_cycle_count;

  always #5 clk = ~clk;

  cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_tick        (i_tick),
    .i_btn_run     (i_run),
    .i_btn_step    (i_step),
    .i_btn_pause   (i_pause),
    .i_halt        (i_halt),
    .o_cpu_en      (o_cpu_en),
    .o_run_state   (o_run_state),
    .o_cycle_count (o_cycle_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int g = 0;          // cycle index; periodic tick when g % 5 == 0
  int tick_mode = 0;  // 0 every 5th cycle, 1 every cycle, 2 random, 3 none

  // Reference model. Button b is accepted when the last DB synchronized samples
  // (raw delayed 2 cycles) all disagree with the accepted level; press event is
  // the accepted level's rising edge seen two cycles later.
  bit rh    [3][DB+1];  // rh[b][j] = raw sampled j+1 edges ago
  bit acc_h [3][3];     // acc_h[b][j] = accepted level j edges ago
  int m_state = 0;
  bit m_en = 1'b0;
  int m_cnt = 0;

  task automatic model_edge();
    bit raw [3];
    bit ev  [3];
    bit flip;
    int ns;
    raw[0] = i_run;
    raw[1] = i_step;
    raw[2] = i_pause;
    if (i_rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j <= DB; j++) rh[b][j] = 1'b0;
        for (int j = 0; j < 3; j++) acc_h[b][j] = 1'b0;
      end
      m_state = 0;
      m_en    = 1'b0;
      m_cnt   = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = acc_h[b][1] && !acc_h[b][2];
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) if (rh[b][j] == acc_h[b][0]) flip = 1'b0;
      acc_h[b][2] = acc_h[b][1];
      acc_h[b][1] = acc_h[b][0];
      acc_h[b][0] = acc_h[b][0] ^ flip;
      for (int j = DB; j >= 1; j--) rh[b][j] = rh[b][j-1];
      rh[b][0] = raw[b];
    end
    m_cnt = (m_cnt + (m_en ? 1 : 0)) % (1 << CW);
    m_en  = i_tick && !i_halt && !ev[2] && (m_state == 1 || m_state == 2);
    ns = m_state;
    case (m_state)
      0: if (i_halt) ns = 3; else if (ev[0]) ns = 1; else if (ev[1]) ns = 2;
      1: if (i_halt) ns = 3; else if (ev[2]) ns = 0;
      2: if (i_halt) ns = 3; else if (i_tick) ns = 0;
      default: ns = 3;
    endcase
    m_state = ns;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, g);
    end
  endtask

  task automatic step();
    case (tick_mode)
      0:       i_tick = (g % 5 == 0);
      1:       i_tick = 1'b1;
      2:       i_tick = ($urandom_range(0, 3) == 0);
      default: i_tick = 1'b0;
    endcase
    model_edge();
    @(posedge clk);
    #1;
    g++;
    n_vec++;
    if (o_run_state !== 2'(m_state) || o_cpu_en !== m_en || o_cycle_count !== CW'(m_cnt)) begin
      n_err++;
      $display("FAIL cycle_model @%0d: state/en/cnt got %0d/%0b/%0d, expected %0d/%0b/%0d",
               g, o_run_state, o_cpu_en, o_cycle_count, m_state, m_en, m_cnt);
    end
  endtask

  task automatic hold(input logic r, input logic s, input logic p, input logic h, input int n);
    i_rst = 1'b0; i_run = r; i_step = s; i_pause = p; i_halt = h;
    repeat (n) step();
  endtask

  task automatic do_rst(input int n);
    i_rst = 1'b1; i_halt = 1'b0;
    repeat (n) step();
    i_rst = 1'b0;
  endtask

  typedef struct {
    logic  rst, run, stp, pause, halt;
    int    n;
    int    st;
    int    cnt;
    string name;
  } seg_t;

  seg_t tbl [6];
  int   c0;
  int   left [3];
  bit   lvl  [3];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3,  0, 0,  "reset"};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7,  0, 0,  "held_pre_event"};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1,  1, 0,  "held_run_latency"};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1, 10, "run_ten_ticks"};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  0, 11, "pause_on_tick"};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 0, 11, "idle_ticks"};

    for (int i = 0; i < 6; i++) begin
      i_rst = tbl[i].rst; i_run = tbl[i].run; i_step = tbl[i].stp;
      i_pause = tbl[i].pause; i_halt = tbl[i].halt;
      repeat (tbl[i].n) step();
      check({tbl[i].name, "_state"}, int'(o_run_state), tbl[i].st);
      check({tbl[i].name, "_count"}, int'(o_cycle_count), tbl[i].cnt);
    end

    // Bouncing run button, then stable press.
    for (int i = 0; i < 10; i++) hold((i % 2) == 0, 1'b0, 1'b0, 1'b0, 2);
    check("bounce_no_event", int'(o_run_state), 0);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    check("bounce_then_run", int'(o_run_state), 1);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8);

    // Short pause glitch in RUN.
    hold(1'b0, 1'b0, 1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 10);
    check("pause_glitch", int'(o_run_state), 1);

    // Ten ticks in RUN, then pause and idle ticks.
    c0 = m_cnt;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 50);
    check("run_count_delta", int'(o_cycle_count), (c0 + 10) % 16);
    hold(1'b0, 1'b0, 1'b1, 1'b0, 8);
    check("pause_to_idle", int'(o_run_state), 0);
    c0 = (m_cnt + (m_en ? 1 : 0)) % 16;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 20);
    check("paused_no_count", int'(o_cycle_count), c0);

    // Single step, with ticks held off so a second press lands inside STEP.
    tick_mode = 3;
    hold(1'b0, 1'b1, 1'b0, 1'b0, 8);
    check("step_enter", int'(o_run_state), 2);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    hold(1'b0, 1'b1, 1'b0, 1'b0, 8);
    check("step_second_press", int'(o_run_state), 2);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    c0 = (m_cnt + 1) % 16;
    tick_mode = 0;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    check("step_done_state", int'(o_run_state), 0);
    check("step_done_count", int'(o_cycle_count), c0);

    // Halt coinciding with a tick in RUN.
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    while (g % 5 != 0) hold(1'b0, 1'b0, 1'b0, 1'b0, 1);
    hold(1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("halt_state", int'(o_run_state), 3);
    check("halt_no_en", int'(o_cpu_en), 0);
    hold(1'b1, 1'b1, 1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    check("halt_absorbing", int'(o_run_state), 3);
    do_rst(1);
    check("rst_state", int'(o_run_state), 0);
    check("rst_count", int'(o_cycle_count), 0);
    check("rst_no_en", int'(o_cpu_en), 0);

    // Pause event and halt in the same cycle.
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    hold(1'b0, 1'b0, 1'b1, 1'b0, 7);
    hold(1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("halt_beats_pause", int'(o_run_state), 3);
    do_rst(2);

    // Tick every cycle and counter wrap.
    tick_mode = 3;
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 6);
    check("wrap_run_state", int'(o_run_state), 1);
    tick_mode = 1;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 9);
    check("every_cycle_en", int'(o_cpu_en), 1);
    check("every_cycle_count", int'(o_cycle_count), 8);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 7);
    check("count_max", int'(o_cycle_count), 15);
    tick_mode = 3;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("count_wrap", int'(o_cycle_count), 0);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("en_stops", int'(o_cpu_en), 0);

    // Random buttons, ticks, halts and resets against the model.
    tick_mode = 2;
    for (int b = 0; b < 3; b++) begin
      left[b] = 0;
      lvl[b]  = 1'b0;
    end
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          left[b] = $urandom_range(1, 14);
        end
        left[b]--;
      end
      i_run   = lvl[0];
      i_step  = lvl[1];
      i_pause = lvl[2];
      i_halt  = ($urandom_range(0, 79) == 0);
      i_rst   = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
